// File: rtl/mil_rx_frame_buffer.sv
// MIL-STD-1553 receive-side frame buffer: FWFT FIFO of {type,word} entries with
// command/data framing tracker. The receiver is never stalled; words arriving while full are dropped.
module mil_rx_frame_buffer #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_request,
    input  logic [1:0]    in_type,
    input  logic [15:0]   in_word,
    output logic          in_done,
    output logic          out_valid,
    output logic [1:0]    out_type,
    output logic [15:0]   out_word,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clear_overflow,
    output logic          frame_done,
    output logic          frame_err,
    output logic          dbg_state
);

    localparam logic [1:0] T_COMMAND = 2'd0;
    localparam logic [1:0] T_STATUS  = 2'd1;
    localparam logic [1:0] T_DATA    = 2'd2;
    localparam logic [1:0] T_ERROR   = 2'd3;

    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    typedef enum logic {ST_IDLE, ST_DATA} state_t;

    logic [17:0]   mem [DEPTH];

    logic          req_q;
    logic          in_done_q;
    logic [17:0]   stage_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          out_valid_q;
    logic [1:0]    out_type_q;
    logic [15:0]   out_word_q;
    logic          overflow_q;
    state_t        state_q;
    logic [5:0]    cnt_q;
    logic          frame_done_q;
    logic          frame_err_q;

    logic          accept;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic [17:0]   head_d;
    logic [5:0]    cmd_wc;

    // Words are taken on the rising edge of in_request; the write itself happens
    // in the ack cycle from the staging register, which gives the 2-cycle fill latency.
    always_comb begin
        accept   = in_request && !req_q && !in_done_q;
        pop      = out_valid_q && out_ready;
        full     = (level_q == FULL_LEVEL);
        wr_en    = in_done_q && (!full || pop);
        drop     = in_done_q && full && !pop;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d  = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // The word being written becomes the head when it lands on the new read slot.
        head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? stage_q : mem[rd_ptr_d];
        cmd_wc = (in_word[4:0] == 5'd0) ? 6'd32 : {1'b0, in_word[4:0]};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= stage_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= 1'b0;
            in_done_q   <= 1'b0;
            stage_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_word_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            req_q     <= in_request;
            in_done_q <= accept;
            if (accept) begin
                stage_q <= {in_type, in_word};
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= (level_d != '0);
            if (level_d != '0) begin
                {out_type_q, out_word_q} <= head_d;
            end else begin
                {out_type_q, out_word_q} <= '0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Frame tracker: judged at acceptance so its pulses line up with in_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (accept) begin
                case (in_type)
                    T_COMMAND: begin
                        if (state_q == ST_DATA) begin
                            frame_err_q <= 1'b1;
                        end
                        if (!in_word[10]) begin
                            cnt_q   <= cmd_wc;
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            if (state_q == ST_IDLE) begin
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                    T_STATUS: begin
                        if (state_q == ST_DATA) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    T_DATA: begin
                        if (state_q == ST_IDLE) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                            if (cnt_q == 6'd1) begin
                                frame_done_q <= 1'b1;
                                state_q      <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_done    = in_done_q;
    assign out_valid  = out_valid_q;
    assign out_type   = out_type_q;
    assign out_word   = out_word_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mil_rx_frame_buffer.sv
// Directed bench for mil_rx_frame_buffer: framing pulses, FWFT ordering, overflow
// and asynchronous reset, checked against a queue of expected FIFO entries.
module tb_mil_rx_frame_buffer;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [1:0] T_COMMAND = 2'd0;
    localparam logic [1:0] T_STATUS  = 2'd1;
    localparam logic [1:0] T_DATA    = 2'd2;
    localparam logic [1:0] T_ERROR   = 2'd3;

    logic          clk;
    logic          rst;
    logic          in_request;
    logic [1:0]    in_type;
    logic [15:0]   in_word;
    logic          in_done;
    logic          out_valid;
    logic [1:0]    out_type;
    logic [15:0]   out_word;
    logic          out_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic          clear_overflow;
    logic          frame_done;
    logic          frame_err;
    logic          dbg_state;

    logic [17:0]   exp_q[$];
    logic          exp_ovf;
    int            n_checks;
    int            n_errors;

    mil_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_request     (in_request),
        .in_type        (in_type),
        .in_word        (in_word),
        .in_done        (in_done),
        .out_valid      (out_valid),
        .out_type       (out_type),
        .out_word       (out_word),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_done"},    32'(in_done),    32'd0);
        check({tag, " out_valid"},  32'(out_valid),  32'd0);
        check({tag, " out_type"},   32'(out_type),   32'd0);
        check({tag, " out_word"},   32'(out_word),   32'd0);
        check({tag, " level"},      32'(level),      32'd0);
        check({tag, " overflow"},   32'(overflow),   32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " frame_err"},  32'(frame_err),  32'd0);
        check({tag, " state"},      32'(dbg_state),  32'd0);
    endtask

    // One edge-qualified push; frame pulses are checked in the ack cycle.
    task automatic push(input string tag, input logic [1:0] t, input logic [15:0] w,
                        input logic exp_done, input logic exp_err);
        @(negedge clk);
        in_type    = t;
        in_word    = w;
        in_request = 1'b1;
        @(negedge clk);
        check({tag, " in_done"},    32'(in_done),    32'd1);
        check({tag, " frame_done"}, 32'(frame_done), 32'(exp_done));
        check({tag, " frame_err"},  32'(frame_err),  32'(exp_err));
        in_request = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back({t, w});
        else exp_ovf = 1'b1;
        @(negedge clk);
        check({tag, " in_done low"}, 32'(in_done),  32'd0);
        check({tag, " level"},       32'(level),    32'(exp_q.size()));
        check({tag, " overflow"},    32'(overflow), 32'(exp_ovf));
    endtask

    // Pop the head at the current negedge, comparing it with the scoreboard first.
    task automatic pop_one(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " head"}, 32'({out_type, out_word}), 32'(exp_q[0]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check({tag, " level"}, 32'(level), 32'(exp_q.size()));
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_one(tag);
        check({tag, " empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        exp_ovf        = 1'b0;
        rst            = 1'b0;
        in_request     = 1'b0;
        in_type        = '0;
        in_word        = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two-word receive frame
        push("t1 cmd", T_COMMAND, 16'h0822, 1'b0, 1'b0);
        push("t1 d1",  T_DATA,    16'h1111, 1'b0, 1'b0);
        push("t1 d2",  T_DATA,    16'h2222, 1'b1, 1'b0);
        check("t1 level3", 32'(level), 32'd3);
        drain("t1 pop");

        // Transmit command completes immediately
        push("t2 tx cmd", T_COMMAND, 16'h0C00, 1'b1, 1'b0);

        // A held request is a single word
        @(negedge clk);
        in_type    = T_STATUS;
        in_word    = 16'hABCD;
        in_request = 1'b1;
        @(negedge clk);
        check("t2 hold ack", 32'(in_done), 32'd1);
        @(negedge clk);
        check("t2 hold no ack a", 32'(in_done), 32'd0);
        @(negedge clk);
        check("t2 hold no ack b", 32'(in_done), 32'd0);
        in_request = 1'b0;
        exp_q.push_back({T_STATUS, 16'hABCD});
        @(negedge clk);
        check("t2 hold level", 32'(level), 32'd2);
        drain("t2 pop");

        // Word count 0 means 32 data words
        push("t3 cmd", T_COMMAND, 16'h0820, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++)
            push($sformatf("t3 d%0d", i), T_DATA, 16'(16'h3000 + i), (i == 31), 1'b0);
        check("t3 level33", 32'(level), 32'd33);
        drain("t3 pop");

        // New command mid-frame is an error and restarts tracking
        push("t4 cmd3", T_COMMAND, 16'h0823, 1'b0, 1'b0);
        push("t4 d1",   T_DATA,    16'h4444, 1'b0, 1'b0);
        push("t4 cmd1", T_COMMAND, 16'h0821, 1'b0, 1'b1);
        push("t4 d2",   T_DATA,    16'h5555, 1'b1, 1'b0);
        push("t4 stray data", T_DATA, 16'h6666, 1'b0, 1'b1);
        push("t4 err word",   T_ERROR, 16'h0000, 1'b0, 1'b1);
        drain("t4 pop");

        // Fill, then overflow
        for (int i = 0; i < DEPTH; i++)
            push($sformatf("t5 fill%0d", i), T_STATUS, 16'(16'h7000 + i), 1'b0, 1'b0);
        push("t5 over", T_STATUS, 16'h7FFF, 1'b0, 1'b0);
        check("t5 level full", 32'(level), 32'(DEPTH));
        check("t5 head kept", 32'({out_type, out_word}), 32'({T_STATUS, 16'h7000}));
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        check("t5 clear", 32'(overflow), 32'd0);

        // Pop and write in the same cycle while full
        in_type    = T_STATUS;
        in_word    = 16'h8888;
        in_request = 1'b1;
        @(negedge clk);
        check("t6 ack", 32'(in_done), 32'd1);
        in_request = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({T_STATUS, 16'h8888});
        check("t6 level", 32'(level), 32'(DEPTH));
        check("t6 overflow", 32'(overflow), 32'd0);
        check("t6 head", 32'({out_type, out_word}), 32'(exp_q[0]));

        // Mid-frame async reset during an ack cycle (FIFO still full, so the command is dropped)
        push("t7 cmd", T_COMMAND, 16'h0823, 1'b0, 1'b0);
        check("t7 in frame", 32'(dbg_state), 32'd1);
        @(negedge clk);
        in_type    = T_DATA;
        in_word    = 16'h9999;
        in_request = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t7 async");
        exp_q.delete();
        exp_ovf = 1'b0;
        in_request = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push("t7 data after reset", T_DATA, 16'hAAAA, 1'b0, 1'b1);
        drain("t7 pop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mil_rx_frame_buffer.md
Name: mil_rx_frame_buffer

Overview:
Downstream consumer of the MIL-STD-1553 receiver's push interface. Accepts decoded words (type + 16-bit word) and stores them in a first-word-fall-through FIFO for the SPI-side reader. Tracks 1553 framing: after each command word it counts the expected data words and flags complete or broken frames. It is never allowed to stall the receiver; when full it drops words and records an overflow.

Parameters:
DEPTH, 64, FIFO depth in words (power of two, ≥4)
AW, $clog2(DEPTH), FIFO address width (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_request  in  1  receiver has a word on in_type/in_word
in_type  in  2  word type (WCOMMAND, WSTATUS, WDATA, WERROR per milStd1553 package)
in_word  in  16  received word
in_done  out  1  one-cycle acknowledge of the current in_request
out_valid  out  1  FIFO head valid
out_type  out  2  head word type
out_word  out  16  head word
out_ready  in  1  consumer pops head when out_valid && out_ready
level  out  AW+1  current FIFO occupancy
overflow  out  1  sticky: a word was dropped
clear_overflow  in  1  synchronous clear of overflow
frame_done  out  1  one-cycle pulse: command frame received completely
frame_err  out  1  one-cycle pulse: framing violation

Behaviour:
- Reset (async, rst=1): FIFO empty, level=0, out_valid=0, out_type=0, out_word=0, in_done=0, overflow=0, frame_done=0, frame_err=0, frame counter=0, tracker in IDLE. A reset mid-frame discards all contents and state.
- Push acceptance: a word is taken on the first clk edge where in_request=1 and the block is not already in an ack cycle. in_done=1 on the following cycle only, then 0. in_request held across several cycles counts as one word. A new word requires in_request to go low and high again (edge-qualified).
- Write: when accepted and (level<DEPTH or a pop occurs in the same cycle), {in_type,in_word} is written. If level==DEPTH and no pop occurs, the word is dropped, overflow is set, and in_done still pulses.
- Pop: on out_valid && out_ready the head advances. out_* reflect the new head next cycle (FWFT). An empty FIFO gives out_valid=0. A push into an empty FIFO gives out_valid=1 one cycle after the write edge.
- level: +1 on write, −1 on pop, unchanged when both occur. Pointers wrap modulo DEPTH.
- overflow: set has priority over clear_overflow in the same cycle.
- Frame tracker (evaluated on accepted words, dropped words included):
  - IDLE: on WCOMMAND with bit10 (T/R)=0, set cnt = (word[4:0]==0 ? 32 : word[4:0]) and go to DATA. With T/R=1 (mode code / transmit), pulse frame_done and stay in IDLE.
  - IDLE: on WDATA, pulse frame_err. WSTATUS is ignored.
  - DATA: on WDATA, cnt−1; when cnt reaches 0, pulse frame_done and go to IDLE.
  - DATA: on WCOMMAND, pulse frame_err and restart tracking with the new command (same rules as IDLE). On WSTATUS, pulse frame_err and go to IDLE.
  - Any state: on WERROR, pulse frame_err and go to IDLE.
  - frame_done and frame_err pulse on the cycle in_done asserts. They are never both high.
- Latency: in_request rise → in_done 1 cycle → out_valid 1 cycle later (2 cycles total when the FIFO is empty).

Test Plan:
- Push WCOMMAND 16'h0822 (RT1, R, SA1, WC=2), then WDATA 16'h1111 and 16'h2222 → three in_done pulses; frame_done once, after the 2nd data word; level=3; pops return the 3 words in order with the correct types.
- Push WCOMMAND 16'h0C00 (T/R=1) → frame_done on that word's ack; frame_err stays 0.
- Push WCOMMAND with WC=0 followed by 32 WDATA (DEPTH=64) → frame_done exactly on the 32nd data word; level=33.
- Push WCOMMAND WC=3, one WDATA, then a new WCOMMAND WC=1 and one WDATA → frame_err on the 2nd command; frame_done on the last data word.
- Fill 64 words with out_ready=0, push a 65th → in_done still pulses, overflow=1, level=64, head unchanged. clear_overflow → overflow=0.
- At level=64, pop and push in the same cycle → word accepted, level stays 64, overflow=0. Assert rst mid-frame → all outputs go to reset values immediately, without waiting for a clk edge.
